mfp_line_draw_engine: RTL and testbench

//  Hardware Bresenham line rasteriser behind the IO_LINE_DRAWING_* GPIO interface of mfp_sys.

---
 rtl/mfp_line_draw_engine_pkg.sv | 19 +
 rtl/mfp_bresenham_step.sv | 53 +++++
 rtl/mfp_line_draw_engine.sv | 198 +++++++++++++++++++
 tb/tb_mfp_line_draw_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_line_draw_engine_pkg.sv
// Shared definitions for the Bresenham line rasteriser.
//   line_state_e : engine FSM states (IDLE -> SETUP -> DRAW -> DONE -> IDLE)
//   DefCoordW    : default coordinate width
//   DefHRes      : default horizontal clip bound
//   DefVRes      : default vertical clip bound
package mfp_line_draw_engine_pkg;

  localparam int unsigned DefCoordW = 13;
  localparam int unsigned DefHRes   = 640;
  localparam int unsigned DefVRes   = 480;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StDraw  = 2'd2,
    StDone  = 2'd3
  } line_state_e;

endpackage

// File: rtl/mfp_bresenham_step.sv
// One combinational Bresenham step.
// Inputs : current point (x_i, y_i), end point (xe_i, ye_i), error term err_i, deltas dx_i
//          (>= 0) and dy_i (<= 0), step directions sx_neg_i / sy_neg_i (1 = step by -1).
// Outputs: next point (x_nxt_o, y_nxt_o), next error err_nxt_o, at_end_o when the current
//          point is the end point.
module mfp_bresenham_step #(
  parameter int unsigned COORD_W = 13
) (
  input  logic [COORD_W-1:0]        x_i,
  input  logic [COORD_W-1:0]        y_i,
  input  logic [COORD_W-1:0]        xe_i,
  input  logic [COORD_W-1:0]        ye_i,
  input  logic signed [COORD_W+1:0] err_i,
  input  logic signed [COORD_W+1:0] dx_i,
  input  logic signed [COORD_W+1:0] dy_i,
  input  logic                      sx_neg_i,
  input  logic                      sy_neg_i,
  output logic [COORD_W-1:0]        x_nxt_o,
  output logic [COORD_W-1:0]        y_nxt_o,
  output logic signed [COORD_W+1:0] err_nxt_o,
  output logic                      at_end_o
);

  logic signed [COORD_W+2:0] e2;
  logic signed [COORD_W+2:0] dx_ext;
  logic signed [COORD_W+2:0] dy_ext;
  logic                      step_x;
  logic                      step_y;

  always_comb begin
    e2     = $signed({err_i, 1'b0});
    dx_ext = $signed({dx_i[COORD_W+1], dx_i});
    dy_ext = $signed({dy_i[COORD_W+1], dy_i});
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);

    // Both decisions use the pre-step e2, so both adjustments may land in one cycle.
    err_nxt_o = err_i;
    x_nxt_o   = x_i;
    y_nxt_o   = y_i;
    if (step_x) begin
      err_nxt_o = err_nxt_o + dy_i;
      x_nxt_o   = sx_neg_i ? (x_i - COORD_W'(1)) : (x_i + COORD_W'(1));
    end
    if (step_y) begin
      err_nxt_o = err_nxt_o + dx_i;
      y_nxt_o   = sy_neg_i ? (y_i - COORD_W'(1)) : (y_i + COORD_W'(1));
    end

    at_end_o = (x_i == xe_i) && (y_i == ye_i);
  end

endmodule

// File: rtl/mfp_line_draw_engine.sv
// Bresenham line rasteriser behind the IO_LINE_DRAWING_* GPIO interface.
// Ports:
//   SI_ClkIn / SI_Reset_N        : clock, synchronous active-low reset
//   IO_LINE_DRAWING_X0..Y1       : endpoints, latched on an accepted START rising edge
//   IO_LINE_DRAWING_START        : rising edge requests a draw (only honoured in IDLE)
//   IO_LINE_DRAWING_RESET        : level abort back to IDLE, clears FINISH
//   IO_LINE_DRAWING_FINISH       : sticky completion flag polled by the CPU
//   BUSY                         : engine in SETUP/DRAW/DONE
//   PIX_X/PIX_Y/PIX_VALID/READY  : clipped pixel stream (valid/ready)
//   PIX_COUNT                    : pixels accepted in the current/last line
module mfp_line_draw_engine
  import mfp_line_draw_engine_pkg::*;
#(
  parameter int unsigned COORD_W = DefCoordW,
  parameter int unsigned H_RES   = DefHRes,
  parameter int unsigned V_RES   = DefVRes
) (
  input  logic               SI_ClkIn,
  input  logic               SI_Reset_N,
  input  logic [COORD_W-1:0] IO_LINE_DRAWING_X0,
  input  logic [COORD_W-1:0] IO_LINE_DRAWING_Y0,
  input  logic [COORD_W-1:0] IO_LINE_DRAWING_X1,
  input  logic [COORD_W-1:0] IO_LINE_DRAWING_Y1,
  input  logic               IO_LINE_DRAWING_START,
  input  logic               IO_LINE_DRAWING_RESET,
  output logic               IO_LINE_DRAWING_FINISH,
  output logic               BUSY,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic               PIX_VALID,
  input  logic               PIX_READY,
  output logic [COORD_W:0]   PIX_COUNT
);

  localparam int unsigned ErrW = COORD_W + 2;

  line_state_e            state_q, state_d;
  logic                   start_q;
  logic [COORD_W-1:0]     x_q, x_d;
  logic [COORD_W-1:0]     y_q, y_d;
  logic [COORD_W-1:0]     xe_q, xe_d;
  logic [COORD_W-1:0]     ye_q, ye_d;
  logic signed [ErrW-1:0] err_q, err_d;
  logic signed [ErrW-1:0] dx_q, dx_d;
  logic signed [ErrW-1:0] dy_q, dy_d;
  logic                   sx_neg_q, sx_neg_d;
  logic                   sy_neg_q, sy_neg_d;
  logic                   finish_q, finish_d;
  logic [COORD_W:0]       count_q, count_d;

  logic                   start_edge;
  logic                   in_clip;
  logic                   handshake;
  logic                   consume;
  logic [COORD_W-1:0]     x_nxt, y_nxt;
  logic signed [ErrW-1:0] err_nxt;
  logic                   at_end;

  logic signed [ErrW-1:0] x0_s, y0_s, xe_s, ye_s;
  logic signed [ErrW-1:0] dx_abs, dy_abs;

  mfp_bresenham_step #(
    .COORD_W (COORD_W)
  ) u_step (
    .x_i       (x_q),
    .y_i       (y_q),
    .xe_i      (xe_q),
    .ye_i      (ye_q),
    .err_i     (err_q),
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .sx_neg_i  (sx_neg_q),
    .sy_neg_i  (sy_neg_q),
    .x_nxt_o   (x_nxt),
    .y_nxt_o   (y_nxt),
    .err_nxt_o (err_nxt),
    .at_end_o  (at_end)
  );

  // Zero-extended 32-bit compare so the bounds need not fit in COORD_W bits.
  assign in_clip    = (32'(x_q) < H_RES) && (32'(y_q) < V_RES);
  assign start_edge = IO_LINE_DRAWING_START && !start_q;
  assign PIX_VALID  = (state_q == StDraw) && in_clip;
  assign handshake  = PIX_VALID && PIX_READY;
  // A clipped point is consumed without waiting for the sink.
  assign consume    = handshake || ((state_q == StDraw) && !in_clip);

  assign PIX_X                  = x_q;
  assign PIX_Y                  = y_q;
  assign PIX_COUNT              = count_q;
  assign IO_LINE_DRAWING_FINISH = finish_q;
  assign BUSY                   = (state_q != StIdle);

  // During SETUP x_q/y_q already hold the start point.
  assign x0_s   = $signed({2'b00, x_q});
  assign y0_s   = $signed({2'b00, y_q});
  assign xe_s   = $signed({2'b00, xe_q});
  assign ye_s   = $signed({2'b00, ye_q});
  assign dx_abs = (xe_s >= x0_s) ? (xe_s - x0_s) : (x0_s - xe_s);
  assign dy_abs = (ye_s >= y0_s) ? (ye_s - y0_s) : (y0_s - ye_s);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    finish_d = finish_q;
    count_d  = count_q;

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          x_d      = IO_LINE_DRAWING_X0;
          y_d      = IO_LINE_DRAWING_Y0;
          xe_d     = IO_LINE_DRAWING_X1;
          ye_d     = IO_LINE_DRAWING_Y1;
          finish_d = 1'b0;
          count_d  = '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        dx_d     = dx_abs;
        dy_d     = -dy_abs;
        err_d    = dx_abs - dy_abs;
        sx_neg_d = (xe_q < x_q);
        sy_neg_d = (ye_q < y_q);
        state_d  = StDraw;
      end
      StDraw: begin
        if (handshake) begin
          count_d = count_q + 1'b1;
        end
        if (consume) begin
          if (at_end) begin
            state_d = StDone;
          end else begin
            x_d   = x_nxt;
            y_d   = y_nxt;
            err_d = err_nxt;
          end
        end
      end
      StDone: begin
        finish_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a simultaneous START edge; the count freezes.
    if (IO_LINE_DRAWING_RESET) begin
      state_d  = StIdle;
      finish_d = 1'b0;
      count_d  = count_q;
    end
  end

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      finish_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      // Sampled every cycle, even under abort, so START must re-rise to retrigger.
      start_q  <= IO_LINE_DRAWING_START;
      x_q      <= x_d;
      y_q      <= y_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      finish_q <= finish_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_mfp_line_draw_engine.sv
// Directed bench for mfp_line_draw_engine with hand-computed pixel sequences.
module tb_mfp_line_draw_engine;

  logic        clk;
  logic        rst_n;
  logic [12:0] lx0, ly0, lx1, ly1;
  logic        lstart;
  logic        labort;
  logic        finish;
  logic        busy;
  logic [12:0] pix_x, pix_y;
  logic        pix_valid;
  logic        ready;
  logic [13:0] pix_count;

  int n_vec;
  int n_miss;

  int hs_x[$];
  int hs_y[$];
  int hs_cyc[$];
  int fin_cyc;
  int idle_busy;

  mfp_line_draw_engine #(
    .COORD_W (13),
    .H_RES   (640),
    .V_RES   (480)
  ) dut (
    .SI_ClkIn               (clk),
    .SI_Reset_N             (rst_n),
    .IO_LINE_DRAWING_X0     (lx0),
    .IO_LINE_DRAWING_Y0     (ly0),
    .IO_LINE_DRAWING_X1     (lx1),
    .IO_LINE_DRAWING_Y1     (ly1),
    .IO_LINE_DRAWING_START  (lstart),
    .IO_LINE_DRAWING_RESET  (labort),
    .IO_LINE_DRAWING_FINISH (finish),
    .BUSY                   (busy),
    .PIX_X                  (pix_x),
    .PIX_Y                  (pix_y),
    .PIX_VALID              (pix_valid),
    .PIX_READY              (ready),
    .PIX_COUNT              (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents endpoints and a one-cycle START pulse; returns 1 ns after the sampling edge.
  task automatic start_line(input int x0, input int y0, input int x1, input int y1);
    @(posedge clk); #1;
    lx0 = 13'(x0); ly0 = 13'(y0); lx1 = 13'(x1); ly1 = 13'(y1);
    lstart = 1'b1;
    @(posedge clk); #1;
    lstart = 1'b0;
    // Endpoint changes after the edge must be ignored.
    lx0 = 13'd999; ly0 = 13'd999; lx1 = 13'd0; ly1 = 13'd0;
  endtask

  // Collects handshakes until FINISH is seen idle. mode 0: READY=1, mode 1: READY 1,0,0,...
  task automatic run_line(input int mode, input int budget);
    logic        prev_stall;
    logic [12:0] px, py;
    hs_x.delete(); hs_y.delete(); hs_cyc.delete();
    fin_cyc    = -1;
    idle_busy  = 0;
    prev_stall = 1'b0;
    px = '0; py = '0;
    for (int c = 0; c < budget; c++) begin
      ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (prev_stall) begin
        check_eq("stall_valid", {31'd0, pix_valid}, 32'd1);
        check_eq("stall_x", {19'd0, pix_x}, {19'd0, px});
        check_eq("stall_y", {19'd0, pix_y}, {19'd0, py});
      end
      prev_stall = pix_valid && !ready;
      px = pix_x;
      py = pix_y;
      if (pix_valid && ready) begin
        hs_x.push_back(int'(pix_x));
        hs_y.push_back(int'(pix_y));
        hs_cyc.push_back(c);
      end
      if (busy && !pix_valid) idle_busy++;
      if (!busy && finish) begin
        fin_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (fin_cyc < 0) check_eq("finish_timeout", 32'd0, 32'd1);
    ready = 1'b1;
  endtask

  int exp2_x[7] = '{5, 5, 4, 4, 4, 3, 3};
  int exp2_y[7] = '{10, 9, 8, 7, 6, 5, 4};

  initial begin
    int hs;
    int rises;
    logic prev_fin;
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; lstart = 1'b0; labort = 1'b0; ready = 1'b1;
    lx0 = '0; ly0 = '0; lx1 = '0; ly1 = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_finish", {31'd0, finish}, 32'd0);
    check_eq("rst_valid", {31'd0, pix_valid}, 32'd0);
    check_eq("rst_count", {18'd0, pix_count}, 32'd0);
    check_eq("rst_x", {19'd0, pix_x}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: horizontal line
    start_line(10, 20, 14, 20);
    run_line(0, 40);
    check_eq("t1_npix", hs_x.size(), 5);
    for (int i = 0; i < hs_x.size() && i < 5; i++) begin
      check_eq("t1_x", hs_x[i], 10 + i);
      check_eq("t1_y", hs_y[i], 20);
      check_eq("t1_cyc", hs_cyc[i], 1 + i);
    end
    check_eq("t1_count", {18'd0, pix_count}, 32'd5);
    if (hs_cyc.size() > 0) check_eq("t1_fin_lat", fin_cyc - hs_cyc[hs_cyc.size()-1], 2);

    // 2: steep negative line
    start_line(5, 10, 3, 4);
    run_line(0, 40);
    check_eq("t2_npix", hs_x.size(), 7);
    for (int i = 0; i < hs_x.size() && i < 7; i++) begin
      check_eq("t2_x", hs_x[i], exp2_x[i]);
      check_eq("t2_y", hs_y[i], exp2_y[i]);
    end
    check_eq("t2_count", {18'd0, pix_count}, 32'd7);
    check_eq("t2_finish", {31'd0, finish}, 32'd1);

    // 3: backpressure
    start_line(10, 20, 14, 20);
    run_line(1, 60);
    check_eq("t3_npix", hs_x.size(), 5);
    for (int i = 0; i < hs_x.size() && i < 5; i++) begin
      check_eq("t3_x", hs_x[i], 10 + i);
      check_eq("t3_y", hs_y[i], 20);
    end
    check_eq("t3_count", {18'd0, pix_count}, 32'd5);

    // 4: clipping at H_RES; SETUP + 4 clipped + DONE are busy with VALID low
    start_line(636, 100, 643, 100);
    run_line(0, 40);
    check_eq("t4_npix", hs_x.size(), 4);
    for (int i = 0; i < hs_x.size() && i < 4; i++) check_eq("t4_x", hs_x[i], 636 + i);
    check_eq("t4_idle_busy", idle_busy, 6);
    check_eq("t4_count", {18'd0, pix_count}, 32'd4);
    check_eq("t4_finish", {31'd0, finish}, 32'd1);

    // 5: abort on the 3rd handshake cycle
    start_line(0, 0, 100, 0);
    ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    labort = 1'b1;
    @(negedge clk);
    check_eq("t5_valid_before", {31'd0, pix_valid}, 32'd1);
    check_eq("t5_x_before", {19'd0, pix_x}, 32'd2);
    @(posedge clk); #1;
    labort = 1'b0;
    @(negedge clk);
    check_eq("t5_valid_after", {31'd0, pix_valid}, 32'd0);
    check_eq("t5_busy_after", {31'd0, busy}, 32'd0);
    check_eq("t5_finish_after", {31'd0, finish}, 32'd0);
    start_line(0, 0, 100, 0);
    run_line(0, 300);
    check_eq("t5_full_npix", hs_x.size(), 101);
    if (hs_x.size() > 0) check_eq("t5_full_last", hs_x[hs_x.size()-1], 100);
    check_eq("t5_full_count", {18'd0, pix_count}, 32'd101);

    // 6: point with START held high, then RESET+START together
    @(posedge clk); #1;
    lx0 = 13'd7; ly0 = 13'd7; lx1 = 13'd7; ly1 = 13'd7;
    lstart = 1'b1;
    hs = 0; rises = 0; prev_fin = finish;
    hs_x.delete(); hs_y.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pix_valid && ready) begin
        hs++;
        hs_x.push_back(int'(pix_x));
        hs_y.push_back(int'(pix_y));
      end
      if (finish && !prev_fin) rises++;
      prev_fin = finish;
      @(posedge clk); #1;
    end
    lstart = 1'b0;
    check_eq("t6_npix", hs, 1);
    check_eq("t6_fin_rises", rises, 1);
    if (hs_x.size() > 0) begin
      check_eq("t6_x", hs_x[0], 7);
      check_eq("t6_y", hs_y[0], 7);
    end
    check_eq("t6_finish", {31'd0, finish}, 32'd1);
    @(posedge clk); #1;
    lstart = 1'b1;
    labort = 1'b1;
    @(posedge clk); #1;
    labort = 1'b0;
    hs = 0; rises = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pix_valid) hs++;
      if (busy) rises++;
      @(posedge clk); #1;
    end
    lstart = 1'b0;
    check_eq("t6_abort_npix", hs, 0);
    check_eq("t6_abort_busy", rises, 0);
    check_eq("t6_abort_finish", {31'd0, finish}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
